pixel_dispatcher: RTL and testbench

// Raster-scans one 640x480 frame and hands each pixel's c = re_c + j*im_c to the

---
 rtl/mandel_pkg.sv | 21 ++
 rtl/pixel_dispatcher_if.sv | 27 ++
 rtl/free_engine_picker.sv | 26 ++
 rtl/pixel_dispatcher.sv | 146 ++++++++++++++
 tb/tb_pixel_dispatcher.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// Shared constants, dispatcher state encoding and width helper for the
// pixel dispatcher slice.
package mandel_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } disp_state_t;

    // Index width for a one-of-n selector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_dispatcher_if.sv
// Engine-array bus: per-engine start/eol pulses, held pixel coordinates and
// c value from the dispatcher, and per-engine done levels back from engines.
interface pixel_dispatcher_if #(
    parameter int NUM_ENGINES = 4,
    parameter int WORD_LENGTH = 32
);
    import mandel_pkg::*;

    logic [NUM_ENGINES-1:0]                  eng_start;
    logic [NUM_ENGINES-1:0]                  eng_eol;
    logic [NUM_ENGINES-1:0][X_W-1:0]         eng_x;
    logic [NUM_ENGINES-1:0][Y_W-1:0]         eng_y;
    logic [NUM_ENGINES-1:0][WORD_LENGTH-1:0] eng_re_c;
    logic [NUM_ENGINES-1:0][WORD_LENGTH-1:0] eng_im_c;
    logic [NUM_ENGINES-1:0]                  eng_done;

    modport master (
        output eng_start, eng_eol, eng_x, eng_y, eng_re_c, eng_im_c,
        input  eng_done
    );

    modport slave (
        input  eng_start, eng_eol, eng_x, eng_y, eng_re_c, eng_im_c,
        output eng_done
    );

endinterface

// File: rtl/free_engine_picker.sv
// Lowest-index priority encoder over the free (not busy) engines.
module free_engine_picker
    import mandel_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int IDX_W       = idx_width(NUM_ENGINES)
) (
    input  logic [NUM_ENGINES-1:0] busy_mask,
    output logic                   valid,
    output logic [IDX_W-1:0]       index
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        // NOTE: outputs get defaults before the loop so no path infers a latch.
        valid = 1'b0;
        index = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (!busy_mask[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pixel_dispatcher.sv
// Raster-scans one frame and issues each pixel's c value to the lowest free
// depth engine, holding that engine's x/y/c until it is issued again.
module pixel_dispatcher #(
    parameter int NUM_ENGINES = 4,
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int H_RES       = mandel_pkg::H_RES,
    parameter int V_RES       = mandel_pkg::V_RES
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [WORD_LENGTH-1:0] re_origin,
    input  logic [WORD_LENGTH-1:0] im_origin,
    input  logic [WORD_LENGTH-1:0] step,
    pixel_dispatcher_if.master     eng,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int X_W   = mandel_pkg::X_W;
    localparam int Y_W   = mandel_pkg::Y_W;
    localparam int IDX_W = mandel_pkg::idx_width(NUM_ENGINES);

    // Reject configurations the counters or fixed-point format cannot hold.
    if (NUM_ENGINES < 1 || NUM_ENGINES > 16 || FRAC >= WORD_LENGTH ||
        H_RES < 1 || H_RES > (1 << X_W) || V_RES < 1 || V_RES > (1 << Y_W)) begin : g_param_check
        $error("pixel_dispatcher: unsupported parameter set");
    end

    mandel_pkg::disp_state_t state;

    logic [NUM_ENGINES-1:0] busy_mask;
    logic [NUM_ENGINES-1:0] done_q;
    logic [NUM_ENGINES-1:0] done_rise;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [WORD_LENGTH-1:0] cur_re;
    logic [WORD_LENGTH-1:0] cur_im;
    logic [WORD_LENGTH-1:0] re_org_q;
    logic [WORD_LENGTH-1:0] step_q;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_ENGINES-1:0] pick_onehot;
    logic                   last_col;
    logic                   last_row;

    free_engine_picker #(
        .NUM_ENGINES(NUM_ENGINES),
        .IDX_W      (IDX_W)
    ) u_picker (
        .busy_mask(busy_mask),
        .valid    (pick_valid),
        .index    (pick_idx)
    );

    // A completion is the rising edge of done; a level left over from the
    // previous pixel is not an edge and never frees the engine.
    assign done_rise   = eng.eng_done & ~done_q;
    assign pick_onehot = NUM_ENGINES'(1) << pick_idx;
    assign last_col    = (x == X_W'(H_RES - 1));
    assign last_row    = (y == Y_W'(V_RES - 1));
    assign busy        = (state != mandel_pkg::IDLE);

    // Frame FSM, engine bookkeeping and registered engine outputs.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            // NOTE: the held engine registers are reset too, so engines sharing
            // this reset never see stale coordinates after a mid-frame abort.
            state        <= mandel_pkg::IDLE;
            busy_mask    <= '0;
            done_q       <= '0;
            x            <= '0;
            y            <= '0;
            cur_re       <= '0;
            cur_im       <= '0;
            re_org_q     <= '0;
            step_q       <= '0;
            frame_done   <= 1'b0;
            eng.eng_start <= '0;
            eng.eng_eol   <= '0;
            eng.eng_x     <= '0;
            eng.eng_y     <= '0;
            eng.eng_re_c  <= '0;
            eng.eng_im_c  <= '0;
        end else begin
            // NOTE: non-blocking throughout so every decision uses pre-edge state.
            done_q        <= eng.eng_done;
            busy_mask     <= busy_mask & ~done_rise;
            eng.eng_start <= '0;
            eng.eng_eol   <= '0;
            frame_done    <= 1'b0;

            case (state)
                mandel_pkg::IDLE: begin
                    if (frame_start) begin
                        state    <= mandel_pkg::SCAN;
                        x        <= '0;
                        y        <= '0;
                        cur_re   <= re_origin;
                        cur_im   <= im_origin;
                        re_org_q <= re_origin;
                        step_q   <= step;
                    end
                end

                mandel_pkg::SCAN: begin
                    if (pick_valid) begin
                        eng.eng_start[pick_idx] <= 1'b1;
                        eng.eng_eol[pick_idx]   <= last_col;
                        eng.eng_x[pick_idx]     <= x;
                        eng.eng_y[pick_idx]     <= y;
                        eng.eng_re_c[pick_idx]  <= cur_re;
                        eng.eng_im_c[pick_idx]  <= cur_im;
                        busy_mask <= (busy_mask & ~done_rise) | pick_onehot;

                        if (last_col) begin
                            x      <= '0;
                            cur_re <= re_org_q;
                            cur_im <= cur_im - step_q;
                            if (last_row) begin
                                state <= mandel_pkg::DRAIN;
                            end else begin
                                y <= y + Y_W'(1);
                            end
                        end else begin
                            x      <= x + X_W'(1);
                            cur_re <= cur_re + step_q;
                        end
                    end
                end

                mandel_pkg::DRAIN: begin
                    if (busy_mask == '0) begin
                        state      <= mandel_pkg::IDLE;
                        frame_done <= 1'b1;
                    end
                end

                default: state <= mandel_pkg::IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher: a 2-engine DUT (full 640-pixel lines, 3 lines)
// and a 1-engine DUT (small full frame), both driven by randomized engines and
// checked every cycle against a pixel-index model of the raster scan.
module tb_pixel_dispatcher;

    localparam int W    = 32;
    localparam int NE0  = 2;
    localparam int H0   = 640;
    localparam int V0   = 3;
    localparam int NE1  = 1;
    localparam int H1   = 12;
    localparam int V1   = 5;
    localparam int MAXE = 2;
    localparam int WAIT_LIMIT = 20000;

    logic         sysclk      = 1'b0;
    logic         reset       = 1'b1;
    logic         frame_start = 1'b0;
    logic [W-1:0] re_origin   = '0;
    logic [W-1:0] im_origin   = '0;
    logic [W-1:0] step        = '0;
    logic         busy0, busy1, fdone0, fdone1;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    pixel_dispatcher_if #(.NUM_ENGINES(NE0), .WORD_LENGTH(W)) bus0 ();
    pixel_dispatcher_if #(.NUM_ENGINES(NE1), .WORD_LENGTH(W)) bus1 ();

    pixel_dispatcher #(.NUM_ENGINES(NE0), .WORD_LENGTH(W), .FRAC(28), .H_RES(H0), .V_RES(V0)) dut0 (
        .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
        .re_origin(re_origin), .im_origin(im_origin), .step(step),
        .eng(bus0.master), .busy(busy0), .frame_done(fdone0)
    );

    pixel_dispatcher #(.NUM_ENGINES(NE1), .WORD_LENGTH(W), .FRAC(28), .H_RES(H1), .V_RES(V1)) dut1 (
        .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
        .re_origin(re_origin), .im_origin(im_origin), .step(step),
        .eng(bus1.master), .busy(busy1), .frame_done(fdone1)
    );

    // Uniform two-engine views of both DUTs.
    logic [MAXE-1:0]         o_start [2];
    logic [MAXE-1:0]         o_eol   [2];
    logic [MAXE-1:0]         o_done  [2];
    logic [MAXE-1:0][9:0]    o_x     [2];
    logic [MAXE-1:0][8:0]    o_y     [2];
    logic [MAXE-1:0][W-1:0]  o_re    [2];
    logic [MAXE-1:0][W-1:0]  o_im    [2];
    logic                    o_busy  [2];
    logic                    o_fdone [2];

    logic [MAXE-1:0] auto_done [2] = '{default: '0};
    logic [MAXE-1:0] man_done  = '0;
    logic            use_auto0 = 1'b0;

    assign bus0.eng_done = use_auto0 ? auto_done[0] : man_done;
    assign bus1.eng_done = auto_done[1][0:0];

    assign o_start[0] = bus0.eng_start;   assign o_start[1] = {1'b0, bus1.eng_start};
    assign o_eol[0]   = bus0.eng_eol;     assign o_eol[1]   = {1'b0, bus1.eng_eol};
    assign o_done[0]  = bus0.eng_done;    assign o_done[1]  = {1'b0, bus1.eng_done};
    assign o_x[0]     = bus0.eng_x;       assign o_x[1]     = {10'd0, bus1.eng_x};
    assign o_y[0]     = bus0.eng_y;       assign o_y[1]     = {9'd0, bus1.eng_y};
    assign o_re[0]    = bus0.eng_re_c;    assign o_re[1]    = {32'd0, bus1.eng_re_c};
    assign o_im[0]    = bus0.eng_im_c;    assign o_im[1]    = {32'd0, bus1.eng_im_c};
    assign o_busy[0]  = busy0;            assign o_busy[1]  = busy1;
    assign o_fdone[0] = fdone0;           assign o_fdone[1] = fdone1;

    function automatic int ne_of(input int d); return (d == 0) ? NE0 : NE1; endfunction
    function automatic int h_of(input int d);  return (d == 0) ? H0  : H1;  endfunction
    function automatic int v_of(input int d);  return (d == 0) ? V0  : V1;  endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pixel k of a frame is (k % H, k / H); its c is origin + x*step on the
    // real axis and origin - y*step on the imaginary axis.
    int                     m_mode [2];   // 0 idle, 1 scanning, 2 draining
    int                     m_k    [2];
    logic [MAXE-1:0]        m_busy [2];
    logic [MAXE-1:0]        m_prev [2];
    logic [W-1:0]           m_re0  [2];
    logic [W-1:0]           m_im0  [2];
    logic [W-1:0]           m_step [2];
    logic [MAXE-1:0]        e_start [2];
    logic [MAXE-1:0]        e_eol   [2];
    logic [MAXE-1:0][9:0]   e_x     [2];
    logic [MAXE-1:0][8:0]   e_y     [2];
    logic [MAXE-1:0][W-1:0] e_re    [2];
    logic [MAXE-1:0][W-1:0] e_im    [2];
    logic                   e_fdone [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0;   m_k[d] = 0;
            m_busy[d] = '0;  m_prev[d] = '0;
            m_re0[d] = '0;   m_im0[d] = '0;  m_step[d] = '0;
            e_start[d] = '0; e_eol[d] = '0;  e_fdone[d] = 1'b0;
            e_x[d] = '0;     e_y[d] = '0;    e_re[d] = '0;  e_im[d] = '0;
        end
    endtask

    task automatic model_step(input int d, input logic [MAXE-1:0] done);
        int fe, px, py;
        e_start[d] = '0;
        e_eol[d]   = '0;
        e_fdone[d] = 1'b0;
        fe = -1;
        for (int i = ne_of(d) - 1; i >= 0; i--)
            if (!m_busy[d][i]) fe = i;
        if (m_mode[d] == 1) begin
            if (fe >= 0) begin
                px = m_k[d] % h_of(d);
                py = m_k[d] / h_of(d);
                e_start[d][fe] = 1'b1;
                e_eol[d][fe]   = (px == h_of(d) - 1);
                e_x[d][fe]     = 10'(px);
                e_y[d][fe]     = 9'(py);
                e_re[d][fe]    = m_re0[d] + W'(px) * m_step[d];
                e_im[d][fe]    = m_im0[d] - W'(py) * m_step[d];
                m_k[d]++;
                if (m_k[d] == h_of(d) * v_of(d)) m_mode[d] = 2;
            end
        end else if (m_mode[d] == 2) begin
            if (m_busy[d] == '0) begin
                m_mode[d]  = 0;
                e_fdone[d] = 1'b1;
            end
        end else if (frame_start) begin
            m_mode[d] = 1;
            m_k[d]    = 0;
            m_re0[d]  = re_origin;
            m_im0[d]  = im_origin;
            m_step[d] = step;
        end
        m_busy[d] = (m_busy[d] & ~(done & ~m_prev[d])) | e_start[d];
        m_prev[d] = done;
    endtask

    // Model advances on the same edges as the DUTs.
    always @(posedge sysclk or posedge reset) begin
        if (reset) model_reset();
        else begin
            model_step(0, o_done[0]);
            model_step(1, o_done[1]);
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge sysclk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_start", d), 64'(o_start[d]), 64'(e_start[d]));
            check($sformatf("d%0d_eol", d),   64'(o_eol[d]),   64'(e_eol[d]));
            check($sformatf("d%0d_x", d),     64'(o_x[d]),     64'(e_x[d]));
            check($sformatf("d%0d_y", d),     64'(o_y[d]),     64'(e_y[d]));
            check($sformatf("d%0d_re", d),    64'(o_re[d]),    64'(e_re[d]));
            check($sformatf("d%0d_im", d),    64'(o_im[d]),    64'(e_im[d]));
            check($sformatf("d%0d_busy", d),  64'(o_busy[d]),  64'(m_mode[d] != 0));
            check($sformatf("d%0d_fdone", d), 64'(o_fdone[d]), 64'(e_fdone[d]));
        end
    end

    // Randomized engines: a start may leave done high one more cycle (stale),
    // then done drops and rises again after 1..4 cycles.
    bit e_pend  [2][MAXE];
    int e_stale [2][MAXE];
    int e_lat   [2][MAXE];

    always @(negedge sysclk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < ne_of(d); i++) begin
                if (reset) begin
                    auto_done[d][i] = 1'b0;
                    e_pend[d][i]    = 1'b0;
                end else begin
                    if (o_start[d][i]) begin
                        e_pend[d][i]  = 1'b1;
                        e_stale[d][i] = int'($urandom_range(0, 1));
                        e_lat[d][i]   = int'($urandom_range(1, 4));
                    end
                    if (e_pend[d][i]) begin
                        if (e_stale[d][i] > 0) e_stale[d][i]--;
                        else begin
                            auto_done[d][i] = 1'b0;
                            if (e_lat[d][i] == 0) begin
                                auto_done[d][i] = 1'b1;
                                e_pend[d][i]    = 1'b0;
                            end else e_lat[d][i]--;
                        end
                    end
                end
            end
        end
    end

    // Per-frame start counter, closed by each frame_done pulse.
    int st_cnt [2] = '{0, 0};
    int fd_cnt [2] = '{0, 0};

    always @(negedge sysclk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) st_cnt[d] = 0;
            else begin
                st_cnt[d] += $countones(o_start[d]);
                if (o_fdone[d]) begin
                    fd_cnt[d]++;
                    check($sformatf("d%0d_frame_starts", d), 64'(st_cnt[d]), 64'(h_of(d) * v_of(d)));
                    st_cnt[d] = 0;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic nxt();
        @(negedge sysclk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        nxt();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy0 && n < WAIT_LIMIT) begin
            nxt();
            n++;
        end
        check(name, 64'(busy0), 64'(0));
    endtask

    function automatic int first_set(input logic [MAXE-1:0] v);
        for (int i = 0; i < MAXE; i++) if (v[i]) return i;
        return 0;
    endfunction

    initial begin
        int n, k, f0, wait_n;
        bit found;

        repeat (3) nxt();
        check("reset_start", 64'(o_start[0]), 64'(0));
        check("reset_busy",  64'(busy0), 64'(0));
        reset = 1'b0;
        nxt();

        // First two issues and engine reuse after a done edge.
        re_origin = 32'hE000_0000;
        im_origin = 32'h1200_0000;
        step      = 32'h0020_0000;
        pulse_start();                                   // N1: SCAN, nothing issued yet
        check("scan_busy", 64'(busy0), 64'(1));
        nxt();                                           // N2
        check("pix0_start", 64'(o_start[0]), 64'(2'b01));
        check("pix0_x",     64'(o_x[0][0]),  64'(0));
        check("pix0_re",    64'(o_re[0][0]), 64'(32'hE000_0000));
        check("pix0_im",    64'(o_im[0][0]), 64'(32'h1200_0000));
        nxt();                                           // N3
        check("pix1_start", 64'(o_start[0]), 64'(2'b10));
        check("pix1_x",     64'(o_x[0][1]),  64'(1));
        check("pix1_re",    64'(o_re[0][1]), 64'(32'hE020_0000));
        check("pix1_im",    64'(o_im[0][1]), 64'(32'h1200_0000));
        nxt();                                           // N4
        check("all_busy_no_start", 64'(o_start[0]), 64'(0));
        man_done[1] = 1'b1;
        nxt();                                           // N5: edge seen, not yet reissued
        check("edge_cycle_no_start", 64'(o_start[0]), 64'(0));
        nxt();                                           // N6
        check("pix2_start", 64'(o_start[0]), 64'(2'b10));
        check("pix2_x",     64'(o_x[0][1]),  64'(2));
        check("pix2_re",    64'(o_re[0][1]), 64'(32'hE040_0000));
        check("eng0_x_held", 64'(o_x[0][0]), 64'(0));
        nxt();                                           // N7: done still high, stale
        check("stale_done_ignored", 64'(o_start[0]), 64'(0));
        man_done = '0;
        nxt();
        use_auto0 = 1'b1;

        // Line wrap.
        n = 0;
        while (!(|(o_start[0] & o_eol[0])) && n < WAIT_LIMIT) begin nxt(); n++; end
        found = |(o_start[0] & o_eol[0]);
        check("eol_found", 64'(found), 64'(1));
        k = first_set(o_start[0] & o_eol[0]);
        check("eol_x", 64'(o_x[0][k]), 64'(639));
        check("eol_y", 64'(o_y[0][k]), 64'(0));
        nxt();
        n = 0;
        while (o_start[0] == '0 && n < WAIT_LIMIT) begin nxt(); n++; end
        check("after_eol_found", 64'(o_start[0] != '0), 64'(1));
        k = first_set(o_start[0]);
        check("wrap_x",  64'(o_x[0][k]),  64'(0));
        check("wrap_y",  64'(o_y[0][k]),  64'(1));
        check("wrap_re", 64'(o_re[0][k]), 64'(32'hE000_0000));
        check("wrap_im", 64'(o_im[0][k]), 64'(32'h11E0_0000));

        // frame_start mid-SCAN must not restart; the frame ends once.
        f0 = fd_cnt[0];
        repeat (20) nxt();
        pulse_start();
        wait_idle("frame0_end");
        check("frame0_done_pulses", 64'(fd_cnt[0] - f0), 64'(1));
        repeat (5) nxt();

        // Random frames.
        for (int r = 0; r < 2; r++) begin
            re_origin = $urandom;
            im_origin = $urandom;
            step      = $urandom;
            f0 = fd_cnt[0];
            pulse_start();
            wait_idle("rand_frame_end");
            check("rand_frame_done_pulses", 64'(fd_cnt[0] - f0), 64'(1));
            repeat (3) nxt();
        end

        // Reset in the middle of a scan.
        re_origin = $urandom;
        step      = $urandom;
        pulse_start();
        wait_n = int'($urandom_range(100, 400));
        repeat (wait_n) nxt();
        check("pre_reset_busy", 64'(busy0), 64'(1));
        reset = 1'b1;
        #1;
        check("rst_busy",  64'(busy0), 64'(0));
        check("rst_start", 64'(o_start[0]), 64'(0));
        check("rst_x",     64'(o_x[0]), 64'(0));
        check("rst_re",    64'(o_re[0]), 64'(0));
        repeat (2) nxt();
        reset = 1'b0;
        nxt();
        check("post_reset_idle", 64'(busy0), 64'(0));

        // Clean frame after the abort.
        im_origin = $urandom;
        f0 = fd_cnt[0];
        pulse_start();
        wait_idle("post_reset_frame_end");
        check("post_reset_done_pulses", 64'(fd_cnt[0] - f0), 64'(1));
        repeat (5) nxt();
        check("d1_frames_completed", 64'(fd_cnt[1] >= 3), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
